// File: rtl/vproc_mem_pkg.sv
// Shared types and constants for the Vicuna multi-port bench memory.
// Struct widths here describe the default 32-bit configuration.
package vproc_mem_pkg;

    localparam int MEM_DW   = 32;
    localparam int MEM_DBEW = MEM_DW / 8;

    // Galois feedback mask for taps 32,22,2,1 with a right-shifting register
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef struct packed {
        logic [31:0]         addr;
        logic                we;
        logic [MEM_DBEW-1:0] be;
        logic [MEM_DW-1:0]   wdata;
    } mem_req_t;

    typedef struct packed {
        logic              rvalid;
        logic              err;
        logic [MEM_DW-1:0] rdata;
    } mem_rsp_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/vproc_mem_lat_pipe.sv
// Fixed-length response delay line; reset drops everything in flight.
module vproc_mem_lat_pipe #(
    parameter int LATENCY = 1,
    parameter int W       = 34
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [LATENCY-1:0][W-1:0] r_stage;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= d_i;
            for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign q_o = r_stage[LATENCY-1];

endmodule

// File: rtl/vproc_mem_model.sv
// Multi-port bench memory: req/gnt per port, fixed response latency,
// optional LFSR grant throttling and a program-end detector on port 0.
module vproc_mem_model
    import vproc_mem_pkg::*;
#(
    parameter int          PORTS      = 2,
    parameter int          MEM_W      = 32,
    parameter int          MEM_SZ     = 262144,
    parameter int          LATENCY    = 1,
    parameter int          STALL_EN   = 0,
    parameter logic [31:0] STALL_SEED = 32'h1,
    parameter logic [31:0] END_ADDR   = 32'h0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [PORTS-1:0]              req_i,
    output logic [PORTS-1:0]              gnt_o,
    input  logic [PORTS-1:0][31:0]        addr_i,
    input  logic [PORTS-1:0]              we_i,
    input  logic [PORTS-1:0][MEM_W/8-1:0] be_i,
    input  logic [PORTS-1:0][MEM_W-1:0]   wdata_i,
    output logic [PORTS-1:0]              rvalid_o,
    output logic [PORTS-1:0]              err_o,
    output logic [PORTS-1:0][MEM_W-1:0]   rdata_o,
    output logic                          prog_end_o
);

    localparam int BE_W  = MEM_W / 8;
    localparam int AW    = $clog2(MEM_SZ);
    localparam int OW    = $clog2(BE_W);
    localparam int IW    = AW - OW;
    localparam int DEPTH = MEM_SZ / BE_W;

    typedef struct packed {
        logic             rvalid;
        logic             err;
        logic [MEM_W-1:0] rdata;
    } rsp_t;

    // Not reset: contents are preloaded by the bench and must survive reset
    logic [MEM_W-1:0] r_mem [DEPTH];
    logic [31:0]      r_lfsr;
    logic             r_prog_end;
    logic [IW-1:0]    w_idx [PORTS];
    logic             w_err [PORTS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr     <= STALL_SEED;
            r_prog_end <= 1'b0;
        end else begin
            r_lfsr     <= lfsr_next(r_lfsr);
            r_prog_end <= gnt_o[0] & ~we_i[0] & (addr_i[0] == END_ADDR);
        end
    end

    // Ascending port order: the highest-index port wins each contested byte
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < PORTS; p++) begin
            if (gnt_o[p] && we_i[p] && !w_err[p]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be_i[p][b]) r_mem[w_idx[p]][b*8 +: 8] <= wdata_i[p][b*8 +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        rsp_t w_d;
        rsp_t w_q;
        logic w_unused_lo;

        assign w_idx[p]    = addr_i[p][AW-1:OW];
        assign w_err[p]    = |addr_i[p][31:AW];
        assign w_unused_lo = ^addr_i[p][OW-1:0];
        assign gnt_o[p]    = req_i[p] & ~((STALL_EN != 0) & r_lfsr[p]);

        // Read samples the array before this cycle's writes land
        assign w_d.rvalid = gnt_o[p];
        assign w_d.err    = gnt_o[p] & w_err[p];
        assign w_d.rdata  = (gnt_o[p] & ~we_i[p] & ~w_err[p]) ? r_mem[w_idx[p]] : '0;

        vproc_mem_lat_pipe #(
            .LATENCY(LATENCY),
            .W      ($bits(rsp_t))
        ) u_pipe (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .d_i  (w_d),
            .q_o  (w_q)
        );

        assign rvalid_o[p] = w_q.rvalid;
        assign err_o[p]    = w_q.err;
        assign rdata_o[p]  = w_q.rdata;
    end

    assign prog_end_o = r_prog_end;

endmodule

// File: tb/tb_vproc_mem_model.sv
// Directed checks on a no-stall LATENCY=3 instance and a randomized
// scoreboard run on a throttled LATENCY=4 instance.
module tb_vproc_mem_model;
    import vproc_mem_pkg::*;

    localparam int LAT_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_a, rst_b;
    logic [1:0]       a_req, a_we, a_gnt, a_rvalid, a_err;
    logic [1:0][31:0] a_addr, a_wd, a_rdata;
    logic [1:0][3:0]  a_be;
    logic             a_pe;
    logic [1:0]       b_req, b_we, b_gnt, b_rvalid, b_err;
    logic [1:0][31:0] b_addr, b_wd, b_rdata;
    logic [1:0][3:0]  b_be;
    logic             b_pe;

    int n_chk = 0;
    int n_fail = 0;

    vproc_mem_model #(
        .PORTS(2), .MEM_W(32), .MEM_SZ(262144), .LATENCY(3),
        .STALL_EN(0), .STALL_SEED(32'h1), .END_ADDR(32'h0)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_a), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr),
        .we_i(a_we), .be_i(a_be), .wdata_i(a_wd), .rvalid_o(a_rvalid), .err_o(a_err),
        .rdata_o(a_rdata), .prog_end_o(a_pe)
    );

    vproc_mem_model #(
        .PORTS(2), .MEM_W(32), .MEM_SZ(262144), .LATENCY(LAT_B),
        .STALL_EN(1), .STALL_SEED(32'h1), .END_ADDR(32'h0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr),
        .we_i(b_we), .be_i(b_be), .wdata_i(b_wd), .rvalid_o(b_rvalid), .err_o(b_err),
        .rdata_o(b_rdata), .prog_end_o(b_pe)
    );

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on dut_a, then walk the 3-cycle response window
    task automatic a_txn(input logic [1:0] req, input logic [1:0] we,
                         input logic [31:0] ad0, input logic [31:0] ad1,
                         input logic [3:0] be0, input logic [3:0] be1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [1:0] xerr, input logic [31:0] xrd0,
                         input logic [31:0] xrd1, input logic xpe, input string tag);
        a_req = req; a_we = we; a_addr[0] = ad0; a_addr[1] = ad1;
        a_be[0] = be0; a_be[1] = be1; a_wd[0] = wd0; a_wd[1] = wd1;
        #1;
        chk(a_gnt, req, {tag, ":gnt"});
        @(posedge clk); #1;
        a_req = 2'b00;
        chk(a_pe, xpe, {tag, ":prog_end"});
        chk(a_rvalid, 2'b00, {tag, ":early1"});
        @(posedge clk); #1;
        chk(a_rvalid, 2'b00, {tag, ":early2"});
        chk(a_pe, 1'b0, {tag, ":pe_width"});
        @(posedge clk); #1;
        chk(a_rvalid, req, {tag, ":rvalid"});
        if (req[0]) begin
            chk(a_err[0], xerr[0], {tag, ":err0"});
            chk(a_rdata[0], xrd0, {tag, ":rdata0"});
        end
        if (req[1]) begin
            chk(a_err[1], xerr[1], {tag, ":err1"});
            chk(a_rdata[1], xrd1, {tag, ":rdata1"});
        end
        @(posedge clk); #1;
        chk(a_rvalid, 2'b00, {tag, ":late"});
    endtask

    // Reference state for dut_b: 16-word window, expected responses by due cycle
    logic [31:0] mem_m [16];
    logic [31:0] lfsr_m;
    mem_rsp_t    q_rsp [2][$];
    int          q_due [2][$];
    int          cyc;
    int          n_stall [2];
    int          n_gnt [2];

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) begin
            n[31] = ~n[31]; n[21] = ~n[21]; n[1] = ~n[1]; n[0] = ~n[0];
        end
        return n;
    endfunction

    task automatic b_cycle(input bit active);
        mem_req_t    rq [2];
        mem_rsp_t    r;
        logic [1:0]  g;
        logic        pe_next;
        logic        oob;
        for (int p = 0; p < 2; p++) begin
            rq[p].addr  = ($urandom_range(0, 15) == 0) ? 32'h0004_0000 + 32'($urandom_range(0, 63)) * 4
                                                       : 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            rq[p].we    = ($urandom_range(0, 2) == 0);
            rq[p].be    = 4'($urandom);
            rq[p].wdata = $urandom;
            b_req[p]  = active && ($urandom_range(0, 9) != 0);
            b_addr[p] = rq[p].addr; b_we[p] = rq[p].we; b_be[p] = rq[p].be; b_wd[p] = rq[p].wdata;
        end
        #1;
        for (int p = 0; p < 2; p++) begin
            g[p] = b_req[p] & ~lfsr_m[p];
            chk(b_gnt[p], g[p], $sformatf("b_gnt%0d@%0d", p, cyc));
            if (b_req[p] && lfsr_m[p]) n_stall[p]++;
            if (g[p]) n_gnt[p]++;
        end
        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                oob      = rq[p].addr >= 32'h0004_0000;
                r.rvalid = 1'b1;
                r.err    = oob;
                r.rdata  = (!rq[p].we && !oob) ? mem_m[rq[p].addr[5:2]] : 32'h0;
                q_rsp[p].push_back(r);
                q_due[p].push_back(cyc + LAT_B);
            end
        end
        pe_next = g[0] && !rq[0].we && rq[0].addr == 32'h0;
        for (int p = 0; p < 2; p++) begin
            if (g[p] && rq[p].we && rq[p].addr < 32'h0004_0000) begin
                for (int b = 0; b < 4; b++)
                    if (rq[p].be[b]) mem_m[rq[p].addr[5:2]][b*8 +: 8] = rq[p].wdata[b*8 +: 8];
            end
        end
        @(posedge clk); #1;
        cyc++;
        lfsr_m = lfsr_step(lfsr_m);
        for (int p = 0; p < 2; p++) begin
            if (q_due[p].size() > 0 && q_due[p][0] == cyc) begin
                r = q_rsp[p].pop_front();
                void'(q_due[p].pop_front());
                chk(b_rvalid[p], 1'b1, $sformatf("b_rvalid%0d@%0d", p, cyc));
                chk(b_err[p], r.err, $sformatf("b_err%0d@%0d", p, cyc));
                chk(b_rdata[p], r.rdata, $sformatf("b_rdata%0d@%0d", p, cyc));
            end else begin
                chk(b_rvalid[p], 1'b0, $sformatf("b_spurious%0d@%0d", p, cyc));
            end
        end
        chk(b_pe, pe_next, $sformatf("b_prog_end@%0d", cyc));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit did_rst;
        int n;
        did_rst = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        a_req = '0; a_we = '0; a_addr = '0; a_be = '0; a_wd = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_be = '0; b_wd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(a_rvalid, 2'b00, "rst_rvalid");
        chk(a_err, 2'b00, "rst_err");
        chk(a_rdata, 64'h0, "rst_rdata");
        chk(a_pe, 1'b0, "rst_prog_end");
        rst_a = 1'b0; rst_b = 1'b0;

        a_txn(2'b01, 2'b01, 32'h100, 32'h0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, "wr100");
        a_txn(2'b10, 2'b00, 32'h0, 32'h100, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 32'hDEADBEEF, 1'b0, "rd100");
        a_txn(2'b10, 2'b10, 32'h0, 32'h200, 4'h0, 4'hF, 32'h0, 32'hAAAAAAAA, 2'b00, 32'h0, 32'h0, 1'b0, "wr200a");
        a_txn(2'b10, 2'b10, 32'h0, 32'h200, 4'h0, 4'b0101, 32'h0, 32'h11223344, 2'b00, 32'h0, 32'h0, 1'b0, "wr200b");
        a_txn(2'b10, 2'b00, 32'h0, 32'h200, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 32'hAA22AA44, 1'b0, "rd200");
        a_txn(2'b10, 2'b10, 32'h0, 32'h0, 4'h0, 4'hF, 32'h0, 32'h12345678, 2'b00, 32'h0, 32'h0, 1'b0, "wr0");
        a_txn(2'b10, 2'b10, 32'h0, 32'h0004_0000, 4'h0, 4'hF, 32'h0, 32'hFFFFFFFF, 2'b10, 32'h0, 32'h0, 1'b0, "wr_oob");
        a_txn(2'b10, 2'b00, 32'h0, 32'h0004_0000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 32'h0, 32'h0, 1'b0, "rd_oob");
        a_txn(2'b10, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 32'h12345678, 1'b0, "rd0_kept");
        a_txn(2'b11, 2'b11, 32'h300, 32'h300, 4'hF, 4'hF, 32'h1, 32'h2, 2'b00, 32'h0, 32'h0, 1'b0, "wr300_both");
        a_txn(2'b01, 2'b00, 32'h300, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h2, 32'h0, 1'b0, "rd300");
        a_txn(2'b11, 2'b10, 32'h300, 32'h300, 4'h0, 4'hF, 32'h0, 32'h5, 2'b00, 32'h2, 32'h0, 1'b0, "rd_vs_wr");
        a_txn(2'b11, 2'b11, 32'h301, 32'h302, 4'b0011, 4'b0110, 32'hAAAAAAAA, 32'hBBBBBBBB, 2'b00, 32'h0, 32'h0, 1'b0, "wr300_part");
        a_txn(2'b10, 2'b00, 32'h0, 32'h300, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 32'h00BBBBAA, 1'b0, "rd300_part");
        a_txn(2'b01, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h12345678, 32'h0, 1'b1, "pe_fetch");
        a_txn(2'b11, 2'b01, 32'h0, 32'h0, 4'hF, 4'h0, 32'h12345678, 32'h0, 2'b00, 32'h0, 32'h12345678, 1'b0, "pe_none");
        a_txn(2'b01, 2'b00, 32'h3, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h12345678, 32'h0, 1'b0, "pe_offset");

        // Fill dut_b's window through port 1, retrying under throttling
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = $urandom;
            b_req = 2'b10; b_we = 2'b10; b_addr[1] = 32'(i) * 4; b_be[1] = 4'hF; b_wd[1] = mem_m[i];
            #1;
            n = 0;
            while (!b_gnt[1] && n < 64) begin
                @(posedge clk); #1;
                n++;
            end
            chk(n < 64, 1'b1, $sformatf("b_init_gnt%0d", i));
            @(posedge clk); #1;
            b_req = 2'b00;
        end
        repeat (LAT_B + 2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        lfsr_m = 32'h1;
        cyc = 0;

        for (int k = 0; k < 1000; k++) begin
            b_cycle(1'b1);
            if (!did_rst && k > 400 && (q_due[0].size() + q_due[1].size()) >= 3) begin
                b_req = 2'b00;
                rst_b = 1'b1;
                #1;
                chk(b_rvalid, 2'b00, "b_rst_rvalid");
                chk(b_pe, 1'b0, "b_rst_prog_end");
                for (int p = 0; p < 2; p++) begin
                    q_rsp[p].delete();
                    q_due[p].delete();
                end
                repeat (2) begin
                    @(posedge clk); #1;
                    cyc++;
                    chk(b_rvalid, 2'b00, "b_rst_hold");
                end
                rst_b = 1'b0;
                lfsr_m = 32'h1;
                did_rst = 1;
            end
        end
        for (int k = 0; k < LAT_B + 2; k++) b_cycle(1'b0);

        chk(did_rst, 1'b1, "b_reset_with_inflight");
        for (int p = 0; p < 2; p++) begin
            chk(n_stall[p] > 0, 1'b1, $sformatf("b_saw_stall%0d", p));
            chk(n_gnt[p] > 0, 1'b1, $sformatf("b_saw_gnt%0d", p));
            chk(q_due[p].size(), 0, $sformatf("b_drained%0d", p));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vproc_mem_model.md
Name: vproc_mem_model

Overview:
- Multi-port, parametrised memory model for Vicuna simulation benches and FPGA smoke tests.
- Replaces the single-port fixed-latency bench memory.
- Adds N independent request ports with a req/gnt handshake, configurable word width and latency, optional pseudo-random grant throttling for backpressure stress, and a registered program-end detector.
- Sits between vproc_top memory ports (instruction, data) and the bench.

Parameters:
- PORTS, 2: number of independent request ports; port 0 is the instruction port.
- MEM_W, 32: data word width in bits; power of two, at least 32.
- MEM_SZ, 262144: memory size in bytes; power of two.
- LATENCY, 1: cycles from grant to rvalid; at least 1.
- STALL_EN, 0: 1 enables LFSR-based grant throttling.
- STALL_SEED, 32'h1: reset value of the 32-bit LFSR; must be non-zero.
- END_ADDR, 32'h0: address that flags program end on port 0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset (asynchronous, active-high)
- req_i  in  PORTS  request valid per port
- gnt_o  out  PORTS  request accepted this cycle
- addr_i  in  PORTS*32  byte address per port
- we_i  in  PORTS  write enable
- be_i  in  PORTS*MEM_W/8  byte enables
- wdata_i  in  PORTS*MEM_W  write data
- rvalid_o  out  PORTS  response valid, one per granted request
- err_o  out  PORTS  response error, qualified by rvalid_o
- rdata_o  out  PORTS*MEM_W  read data, qualified by rvalid_o
- prog_end_o  out  1  one-cycle pulse, registered

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: rvalid_o=0, err_o=0, rdata_o=0, prog_end_o=0; latency pipelines cleared; LFSR=STALL_SEED. Memory contents are NOT cleared, because the bench preloads them via hierarchical $readmemh. Reset asserted mid-operation drops all in-flight responses.
- Grant (combinational): gnt_o[p] = req_i[p] & ~stall[p].
  - stall[p] = 0 when STALL_EN=0.
  - Otherwise stall[p] = LFSR bit p, LFSR advancing every cycle (Galois, taps 32,22,2,1).
- Address decode:
  - Word index = addr[$clog2(MEM_SZ)-1:$clog2(MEM_W/8)]; low byte-offset bits are ignored.
  - err = addr[31:$clog2(MEM_SZ)] != 0.
- Granted access in cycle t:
  - Read data is sampled in t from the pre-write array contents (read-before-write).
  - Writes commit at the clock edge ending t for bytes where be=1, but only if err=0. An out-of-range write is dropped and still returns err=1.
- Response: rvalid_o, err_o and rdata_o are asserted exactly LATENCY cycles after the grant cycle; LATENCY=1 means the next cycle.
  - rdata_o is 0 for writes and for err responses.
  - Throughput is one request per port per cycle; there is no response backpressure.
- Same-cycle write conflict (same word, overlapping bytes): the highest-index port wins per byte.
- A read on port A and a write on port B to the same word in the same cycle: the read returns old data.
- prog_end_o = 1 in cycle t+1 iff in cycle t gnt_o[0]=1, we_i[0]=0 and addr_i[0]==END_ADDR.
- Ports are fully independent. No ordering is guaranteed across ports.

Decomposition:
- Package vproc_mem_pkg holds:
  - typedef mem_req_t {addr, we, be, wdata}, parametrised via MEM_W localparams;
  - typedef mem_rsp_t {rvalid, err, rdata};
  - constant LFSR_TAPS.
- Sub-module vproc_mem_lat_pipe (parameters LATENCY, W; resettable shift register of mem_rsp_t), instantiated once per port in a generate loop.
- Array, decode and arbitration stay in the top module.

Test Plan:
- Preload word 0x100 = 0xDEADBEEF; port 1 reads 0x100 at LATENCY=3 -> rvalid_o[1]=1 exactly 3 cycles after gnt, rdata=0xDEADBEEF, err=0.
- Port 1 writes 0x200 with be=4'b0101, wdata=0x11223344 over 0xAAAAAAAA -> read-back 0xAA22AA44. Port 1 writes 0x0004_0000 -> err=1, and word 0 is unchanged.
- Ports 0 and 1 write word 0x300 in the same cycle with 0x1 and 0x2 -> read-back 0x2.
  - Then port 0 reads and port 1 writes 0x5 to 0x300 in one cycle -> port 0 read returns 0x2.
- STALL_EN=1, seed 0x1, 1000 back-to-back requests on both ports -> every granted request gets exactly one response. No response occurs without a grant, and both stall values are observed.
- Reset asserted with 3 reads in flight (LATENCY=4) -> rvalid_o drops to 0 immediately and no stale response appears after release. Memory contents are retained.
- Port 0 fetch at END_ADDR=0 -> prog_end_o pulses for one cycle. A write to 0 on port 0 and a read of 0 on port 1 -> no pulse.
